// File: rtl/armleocpu_divider_controller.sv
// Signed/unsigned RV32M divide controller around an unsigned divider.
// Handles sign fixup, special-case shortcuts, kill and drain.
module armleocpu_divider_controller #(
  parameter bit SHORTCUT_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        kill,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        div_fetch,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_ready,
  input  logic        div_division_by_zero,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, DRAIN, RESP
  } state_t;

  state_t      state, state_n;
  logic        op_rem, op_rem_n;
  logic        neg_q, neg_q_n;
  logic        neg_r, neg_r_n;
  logic [31:0] rs1_q, rs1_q_n;
  logic [31:0] result_n;
  logic [31:0] dividend_n, divisor_n;

  logic        req_signed;
  logic        is_dbz, is_ovf;
  logic [31:0] rs1_mag, rs2_mag;
  logic [31:0] quot_fix, rem_fix;

  assign req_signed = ~req_op[0];
  assign is_dbz = (req_rs2 == 32'd0);
  assign is_ovf = req_signed
    && (req_rs1 == 32'h8000_0000)
    && (req_rs2 == 32'hFFFF_FFFF);
  assign rs1_mag = (req_signed && req_rs1[31])
    ? (~req_rs1 + 32'd1) : req_rs1;
  assign rs2_mag = (req_signed && req_rs2[31])
    ? (~req_rs2 + 32'd1) : req_rs2;
  assign quot_fix = neg_q
    ? (~div_quotient + 32'd1) : div_quotient;
  assign rem_fix = neg_r
    ? (~div_remainder + 32'd1) : div_remainder;

  // Next-state, operand latch and result selection
  always_comb begin
    state_n    = state;
    op_rem_n   = op_rem;
    neg_q_n    = neg_q;
    neg_r_n    = neg_r;
    rs1_q_n    = rs1_q;
    result_n   = resp_result;
    dividend_n = div_dividend;
    divisor_n  = div_divisor;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          op_rem_n   = req_op[1];
          neg_q_n    = req_signed
            && (req_rs1[31] ^ req_rs2[31]);
          neg_r_n    = req_signed && req_rs1[31];
          rs1_q_n    = req_rs1;
          dividend_n = rs1_mag;
          divisor_n  = rs2_mag;
          if (SHORTCUT_SPECIAL && is_dbz) begin
            state_n  = RESP;
            result_n = req_op[1]
              ? req_rs1 : 32'hFFFF_FFFF;
          end else if (SHORTCUT_SPECIAL && is_ovf) begin
            state_n  = RESP;
            result_n = req_op[1]
              ? 32'd0 : 32'h8000_0000;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: state_n = kill ? DRAIN : WAIT;
      WAIT: begin
        if (kill) begin
          state_n = div_ready ? IDLE : DRAIN;
        end else if (div_ready) begin
          state_n = RESP;
          if (div_division_by_zero)
            result_n = op_rem
              ? rs1_q : 32'hFFFF_FFFF;
          else
            result_n = op_rem
              ? rem_fix : quot_fix;
        end
      end
      DRAIN: begin
        if (div_ready) state_n = IDLE;
      end
      RESP: begin
        if (kill || resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_rem       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      rs1_q        <= 32'd0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_result  <= 32'd0;
      div_fetch    <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
    end else begin
      state        <= state_n;
      op_rem       <= op_rem_n;
      neg_q        <= neg_q_n;
      neg_r        <= neg_r_n;
      rs1_q        <= rs1_q_n;
      req_ready    <= (state_n == IDLE);
      resp_valid   <= (state_n == RESP);
      resp_result  <= result_n;
      div_fetch    <= (state_n == ISSUE);
      div_dividend <= dividend_n;
      div_divisor  <= divisor_n;
    end
  end

endmodule

// File: tb/tb_armleocpu_divider_controller.sv
// Directed bench for the divider controller.
// A behavioural unsigned divider with programmable latency sits behind it.
module tb_armleocpu_divider_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = 32'd0;
  logic [31:0] req_rs2 = 32'd0;
  logic        kill = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic        div_fetch;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_ready;
  logic        div_division_by_zero;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  int errors = 0;
  int checks = 0;
  int fetch_cnt = 0;
  int div_lat = 3;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  always #5 clk = ~clk;

  armleocpu_divider_controller dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_op               (req_op),
    .req_rs1              (req_rs1),
    .req_rs2              (req_rs2),
    .kill                 (kill),
    .resp_valid           (resp_valid),
    .resp_ready           (resp_ready),
    .resp_result          (resp_result),
    .div_fetch            (div_fetch),
    .div_dividend         (div_dividend),
    .div_divisor          (div_divisor),
    .div_ready            (div_ready),
    .div_division_by_zero (div_division_by_zero),
    .div_quotient         (div_quotient),
    .div_remainder        (div_remainder)
  );

  // Behavioural divider stub with div_lat cycles of latency
  logic        busy;
  int          cnt;
  logic [31:0] m_a, m_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= 0;
      div_ready <= 1'b0;
      div_division_by_zero <= 1'b0;
      div_quotient <= 32'd0;
      div_remainder <= 32'd0;
      m_a <= 32'd0;
      m_b <= 32'd0;
    end else begin
      div_ready <= 1'b0;
      if (div_fetch) begin
        fetch_cnt <= fetch_cnt + 1;
        busy <= 1'b1;
        cnt <= div_lat;
        m_a <= div_dividend;
        m_b <= div_divisor;
      end else if (busy) begin
        if (cnt == 0) begin
          busy <= 1'b0;
          div_ready <= 1'b1;
          div_division_by_zero <= (m_b == 0);
          div_quotient <= (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
          div_remainder <= (m_b == 0) ? m_a : m_a % m_b;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic start_op(input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
    req_valid = 1'b1;
    req_op = op;
    req_rs1 = a;
    req_rs2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output bit to);
    lat = 0;
    to = 1'b0;
    while (!resp_valid) begin
      if (lat >= 60) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({req_ready, resp_valid, div_fetch} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got=%b want=100",
               {req_ready, resp_valid, div_fetch});
    end
    checks++;
    if ({resp_result, div_dividend, div_divisor} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data got=%h %h %h want=0",
               resp_result, div_dividend, div_divisor);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat;
    bit to;
    int f0;
    logic [1:0] ops[2] = '{OP_DIVU, OP_REMU};
    logic [31:0] exp[2] = '{32'd14, 32'd2};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL unsigned_ready%0d got=%b want=1", i, req_ready);
      end
      f0 = fetch_cnt;
      start_op(ops[i], 32'd100, 32'd7);
      wait_resp(lat, to);
      checks++;
      if (to || resp_result !== exp[i]) begin
        errors++;
        $display("FAIL unsigned%0d got=%h timeout=%0d want=%h",
                 i, resp_result, to, exp[i]);
      end
      checks++;
      if (fetch_cnt - f0 != 1) begin
        errors++;
        $display("FAIL unsigned_fetch%0d got=%0d want=1",
                 i, fetch_cnt - f0);
      end
      finish_resp();
      checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL unsigned_done%0d got=%b want=01",
                 i, {resp_valid, req_ready});
      end
    end
  endtask

  task automatic test_signed();
    int lat;
    bit to;
    logic [1:0] ops[3] = '{OP_DIV, OP_REM, OP_REM};
    logic [31:0] as[3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
    logic [31:0] bs[3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
    logic [31:0] exp[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
    for (int i = 0; i < 3; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_resp(lat, to);
      checks++;
      if (to || resp_result !== exp[i]) begin
        errors++;
        $display("FAIL signed%0d got=%h timeout=%0d want=%h",
                 i, resp_result, to, exp[i]);
      end
      finish_resp();
    end
  endtask

  task automatic test_special();
    int lat;
    bit to;
    int f0;
    logic [1:0] ops[4] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] as[4] = '{32'd5, 32'h1234,
                           32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[4] = '{32'd0, 32'd0,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp[4] = '{32'hFFFF_FFFF, 32'h1234,
                            32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      f0 = fetch_cnt;
      start_op(ops[i], as[i], bs[i]);
      wait_resp(lat, to);
      checks++;
      if (lat != 0 || resp_result !== exp[i]) begin
        errors++;
        $display("FAIL special%0d got=%h lat=%0d want=%h lat=0",
                 i, resp_result, lat, exp[i]);
      end
      checks++;
      if (fetch_cnt != f0 || div_fetch !== 1'b0) begin
        errors++;
        $display("FAIL special_fetch%0d got=%0d want=0",
                 i, fetch_cnt - f0);
      end
      finish_resp();
    end
  endtask

  task automatic test_kill_wait();
    int lat;
    bit to;
    bit bad;
    bit seen;
    div_lat = 6;
    bad = 1'b0;
    seen = 1'b0;
    start_op(OP_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) bad = 1'b1;
      if (div_ready) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bad || !seen) begin
      errors++;
      $display("FAIL drain bad=%0d div_ready_seen=%0d want=0 1",
               bad, seen);
    end
    @(posedge clk); #1;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL drain_exit got=%b want=10",
               {req_ready, resp_valid});
    end
    div_lat = 3;
    start_op(OP_DIVU, 32'd9, 32'd3);
    wait_resp(lat, to);
    checks++;
    if (to || resp_result !== 32'd3) begin
      errors++;
      $display("FAIL after_kill got=%h timeout=%0d want=3",
               resp_result, to);
    end
    finish_resp();
  endtask

  task automatic test_kill_ready_same();
    bit seen;
    seen = 1'b0;
    start_op(OP_DIVU, 32'd50, 32'd5);
    for (int i = 0; i < 30; i++) begin
      if (div_ready) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if (!seen || {req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL kill_and_ready got=%b seen=%0d want=10",
               {req_ready, resp_valid}, seen);
    end
  endtask

  task automatic test_kill_resp();
    start_op(OP_DIV, 32'd1, 32'd0);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL kill_resp got=%b want=10",
               {req_ready, resp_valid});
    end
  endtask

  task automatic test_stall();
    int lat;
    bit to;
    bit bad;
    bad = 1'b0;
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_resp(lat, to);
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || resp_result !== 32'd14
          || req_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (to || bad || resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall got_bad=%0d timeout=%0d result=%h want=0 0 0000000e",
               bad, to, resp_result);
    end
    finish_resp();
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_done got=%b want=01",
               {resp_valid, req_ready});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit to;
    div_lat = 6;
    start_op(OP_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, div_fetch} !== 3'b100
        || {resp_result, div_dividend, div_divisor} !== 96'd0) begin
      errors++;
      $display("FAIL reset_mid got=%b %h %h %h want=100 0 0 0",
               {req_ready, resp_valid, div_fetch},
               resp_result, div_dividend, div_divisor);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    div_lat = 3;
    start_op(OP_DIVU, 32'd10, 32'd5);
    wait_resp(lat, to);
    checks++;
    if (to || resp_result !== 32'd2) begin
      errors++;
      $display("FAIL after_reset got=%h timeout=%0d want=2",
               resp_result, to);
    end
    finish_resp();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_kill_wait();
    test_kill_ready_same();
    test_kill_resp();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/armleocpu_divider_controller.md
ARMLEOCPU_DIVIDER_CONTROLLER -- requirements
Module: armleocpu_divider_controller

Interface
REQ-001 Parameter SHORTCUT_SPECIAL, default 1: when 1, divide-by-zero and signed overflow complete without starting the divider.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  controller can accept a request; high only in IDLE.
REQ-006 req_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 req_rs1 / req_rs2  input  32 each  dividend / divisor.
REQ-008 kill  input  1  abandon the in-flight operation.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts the result.
REQ-011 resp_result  output  32  result value.
REQ-012 div_fetch  output  1  start pulse to the unsigned divider.
REQ-013 div_dividend / div_divisor  output  32 each  unsigned operands to the divider.
REQ-014 div_ready, div_division_by_zero  input  1 each  divider completion and zero-divisor flags.
REQ-015 div_quotient / div_remainder  input  32 each  divider results, valid while div_ready=1.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT, DRAIN and RESP, with all outputs registered.
REQ-017 Handshake: req_valid&&req_ready at edge T SHALL latch op, operand signs and magnitudes.
REQ-018 Operand conversion: signed ops (DIV, REM) SHALL use the two's-complement magnitude of each negative operand, and unsigned ops SHALL pass operands through.
REQ-019 neg_q = rs1[31]^rs2[31] and neg_r = rs1[31] SHALL be latched for signed ops, and both SHALL be 0 for unsigned ops.
REQ-020 Special case, divisor==0 with SHORTCUT_SPECIAL=1: IDLE->RESP; DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1.
REQ-021 Special case, DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF with SHORTCUT_SPECIAL=1: IDLE->RESP; DIV result 0x80000000; REM result 0.
REQ-022 Normal path: IDLE->ISSUE, where ISSUE drives div_fetch=1 for exactly one cycle with stable operands, then ->WAIT.
REQ-023 div_fetch SHALL be 0 in every state other than ISSUE.
REQ-024 In WAIT, div_ready=1 SHALL capture the result and move to RESP.
REQ-025 Captured quotient SHALL be negated if neg_q, and captured remainder SHALL be negated if neg_r.
REQ-026 When SHORTCUT_SPECIAL=0 and div_division_by_zero=1, the result SHALL be the same value required by REQ-020.
REQ-027 RESP SHALL hold resp_valid=1 and a stable resp_result until resp_ready=1, then go ->IDLE with resp_valid=0 on the next cycle.
REQ-028 Latency, shortcut path: resp_valid SHALL be 1 in cycle T+1.
REQ-029 Latency, normal path: resp_valid SHALL be 1 in the cycle after div_ready is sampled high.
REQ-030 kill in ISSUE or WAIT: because the divider cannot be aborted, the controller SHALL go ->DRAIN, remain there until div_ready, discard the result, then go ->IDLE.
REQ-031 req_ready SHALL be 0 during DRAIN.
REQ-032 kill in RESP SHALL drop resp_valid next cycle and go ->IDLE.
REQ-033 kill in IDLE SHALL be ignored.
REQ-034 kill and div_ready in the same WAIT cycle: kill wins, go ->IDLE directly, and resp_valid SHALL stay 0.
REQ-035 An unexpected div_ready in IDLE or RESP SHALL be ignored.
REQ-036 Throughput: a new request SHALL be accepted no earlier than the cycle after the RESP handshake (no overlap).

Reset
REQ-037 While rst_n=0 (asynchronous), the following SHALL hold:
- state=IDLE
- req_ready=1
- resp_valid=0
- resp_result=0
- div_fetch=0
- div_dividend=0
- div_divisor=0
REQ-038 Reset asserted mid-operation SHALL abandon the operation with no response; the divider's own reset is driven by the same rst_n.
REQ-039 First request acceptance SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-040 DIVU 100/7 -> single div_fetch pulse, resp_result=14; REMU same operands -> 2.
REQ-041 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-042 DIV x/0 -> 0xFFFFFFFF at T+1 with no div_fetch; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-043 kill in WAIT -> DRAIN, req_ready=0 until div_ready, no resp_valid; next DIVU 9/3 -> 3.
REQ-044 resp_ready held 0 for 5 cycles -> resp_valid and resp_result stable throughout; req_ready=0 throughout.
REQ-045 rst_n pulsed low during WAIT -> outputs reach their reset values immediately; after release, DIVU 10/5 -> 2.
